// File: rtl/sirv_qspi_xip_seq.sv
// Execute-in-place byte-read sequencer: command, address, pad and data-receive beats on the QSPI link.
// Optional macro SIRV_QSPI_XIP_MERGE_EN: a read of the next sequential byte skips cmd/addr/pad and keeps CS asserted.
module sirv_qspi_xip_seq #(
   parameter int ADDR_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_en,
   input  logic              io_insn_cmd_en,
   input  logic [7:0]        io_insn_cmd_code,
   input  logic [1:0]        io_insn_cmd_proto,
   input  logic [2:0]        io_insn_addr_len,
   input  logic [1:0]        io_insn_addr_proto,
   input  logic [3:0]        io_insn_pad_cnt,
   input  logic [7:0]        io_insn_pad_code,
   input  logic [1:0]        io_insn_data_proto,
   input  logic              io_addr_valid,
   output logic              io_addr_ready,
   input  logic [ADDR_W-1:0] io_addr_bits,
   output logic              io_data_valid,
   input  logic              io_data_ready,
   output logic [7:0]        io_data_bits,
   input  logic              io_link_tx_ready,
   output logic              io_link_tx_valid,
   output logic [7:0]        io_link_tx_bits,
   output logic [3:0]        io_link_cnt,
   output logic [1:0]        io_link_fmt_proto,
   output logic              io_link_fmt_iodir,
   output logic              io_link_cs_clear,
   input  logic              io_link_rx_valid,
   input  logic [7:0]        io_link_rx_bits,
   output logic              io_link_lock
);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, PAD, DRX, WRX, RESP} state_t;

   state_t            state, state_nx, post_addr, post_cmd, first_state;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        k_q;
   logic              cs_pend;
   logic [7:0]        data_q;
   logic [2:0]        alen;
   logic              ready_w, acc, tx_fire, merge_hit;

   assign alen    = (io_insn_addr_len > 3'd4) ? 3'd4 : io_insn_addr_len;
   assign ready_w = (state == IDLE) & io_en & ~reset;
   assign acc     = io_addr_valid & ready_w;
   assign tx_fire = io_link_tx_valid & io_link_tx_ready;

   assign io_addr_ready    = ready_w;
   assign io_data_bits     = data_q;
   assign io_link_cs_clear = io_link_tx_valid & cs_pend;
   assign io_link_lock     = (state != IDLE);

`ifdef SIRV_QSPI_XIP_MERGE_EN
   logic              merge_q;
   logic [ADDR_W-1:0] next_addr_q;

   assign merge_hit = merge_q & (io_addr_bits == next_addr_q);

   always_ff @(posedge clock) begin
      if (reset) begin
         merge_q     <= 1'b0;
         next_addr_q <= '0;
      end else if (state == RESP && io_data_ready) begin
         merge_q     <= 1'b1;
         next_addr_q <= addr_q + ADDR_W'(1);
      end else if (state == IDLE && (!io_en || acc)) begin
         merge_q     <= 1'b0;
      end
   end
`else
   assign merge_hit = 1'b0;
`endif

   always_comb begin
      post_addr   = (io_insn_pad_cnt != 4'd0) ? PAD : DRX;
      post_cmd    = (alen != 3'd0) ? ADDR : post_addr;
      first_state = io_insn_cmd_en ? CMD : post_cmd;
   end

   always_comb begin
      state_nx          = state;
      io_data_valid     = 1'b0;
      io_link_tx_valid  = 1'b0;
      io_link_tx_bits   = '0;
      io_link_cnt       = 4'd8;
      io_link_fmt_proto = '0;
      io_link_fmt_iodir = 1'b0;
      case (state)
         IDLE: if (acc) state_nx = merge_hit ? DRX : first_state;
         CMD: begin
            io_link_tx_valid  = 1'b1;
            io_link_tx_bits   = io_insn_cmd_code;
            io_link_fmt_proto = io_insn_cmd_proto;
            io_link_fmt_iodir = 1'b1;
            if (io_link_tx_ready) state_nx = post_cmd;
         end
         ADDR: begin
            io_link_tx_valid  = 1'b1;
            io_link_tx_bits   = addr_q[{k_q, 3'b000} +: 8];
            io_link_fmt_proto = io_insn_addr_proto;
            io_link_fmt_iodir = 1'b1;
            if (io_link_tx_ready && k_q == 2'd0) state_nx = post_addr;
         end
         PAD: begin
            io_link_tx_valid  = 1'b1;
            io_link_tx_bits   = io_insn_pad_code;
            io_link_cnt       = io_insn_pad_cnt;
            io_link_fmt_proto = io_insn_data_proto;
            io_link_fmt_iodir = 1'b1;
            if (io_link_tx_ready) state_nx = DRX;
         end
         DRX: begin
            io_link_tx_valid  = 1'b1;
            io_link_fmt_proto = io_insn_data_proto;
            if (io_link_tx_ready) state_nx = WRX;
         end
         WRX: if (io_link_rx_valid) state_nx = RESP;
         RESP: begin
            io_data_valid = 1'b1;
            if (io_data_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // cs_pend marks the first beat of a fresh (non-merged) transaction
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         addr_q  <= '0;
         k_q     <= '0;
         cs_pend <= 1'b0;
         data_q  <= '0;
      end else begin
         state <= state_nx;
         if (acc) begin
            addr_q  <= io_addr_bits;
            k_q     <= 2'(alen - 3'd1);
            cs_pend <= ~merge_hit;
         end else begin
            if (state == ADDR && tx_fire) k_q <= k_q - 2'd1;
            if (tx_fire) cs_pend <= 1'b0;
         end
         if (state == WRX && io_link_rx_valid) data_q <= io_link_rx_bits;
      end
   end

endmodule

// File: tb/tb_sirv_qspi_xip_seq.sv
// Self-checking bench for sirv_qspi_xip_seq: transaction-level beat/response model plus directed literal checks.
module tb_sirv_qspi_xip_seq;
   localparam int ADDR_W = 32;

   logic              clock, reset, io_en;
   logic              io_insn_cmd_en;
   logic [7:0]        io_insn_cmd_code;
   logic [1:0]        io_insn_cmd_proto;
   logic [2:0]        io_insn_addr_len;
   logic [1:0]        io_insn_addr_proto;
   logic [3:0]        io_insn_pad_cnt;
   logic [7:0]        io_insn_pad_code;
   logic [1:0]        io_insn_data_proto;
   logic              io_addr_valid, io_addr_ready;
   logic [ADDR_W-1:0] io_addr_bits;
   logic              io_data_valid, io_data_ready;
   logic [7:0]        io_data_bits;
   logic              io_link_tx_ready, io_link_tx_valid;
   logic [7:0]        io_link_tx_bits;
   logic [3:0]        io_link_cnt;
   logic [1:0]        io_link_fmt_proto;
   logic              io_link_fmt_iodir, io_link_cs_clear;
   logic              io_link_rx_valid;
   logic [7:0]        io_link_rx_bits;
   logic              io_link_lock;

   sirv_qspi_xip_seq #(.ADDR_W(ADDR_W)) dut (
      .clock(clock), .reset(reset), .io_en(io_en),
      .io_insn_cmd_en(io_insn_cmd_en), .io_insn_cmd_code(io_insn_cmd_code),
      .io_insn_cmd_proto(io_insn_cmd_proto), .io_insn_addr_len(io_insn_addr_len),
      .io_insn_addr_proto(io_insn_addr_proto), .io_insn_pad_cnt(io_insn_pad_cnt),
      .io_insn_pad_code(io_insn_pad_code), .io_insn_data_proto(io_insn_data_proto),
      .io_addr_valid(io_addr_valid), .io_addr_ready(io_addr_ready), .io_addr_bits(io_addr_bits),
      .io_data_valid(io_data_valid), .io_data_ready(io_data_ready), .io_data_bits(io_data_bits),
      .io_link_tx_ready(io_link_tx_ready), .io_link_tx_valid(io_link_tx_valid),
      .io_link_tx_bits(io_link_tx_bits), .io_link_cnt(io_link_cnt),
      .io_link_fmt_proto(io_link_fmt_proto), .io_link_fmt_iodir(io_link_fmt_iodir),
      .io_link_cs_clear(io_link_cs_clear), .io_link_rx_valid(io_link_rx_valid),
      .io_link_rx_bits(io_link_rx_bits), .io_link_lock(io_link_lock)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [7:0] bits;
      logic [3:0] cnt;
      logic [1:0] proto;
      logic       iodir;
      logic       cs;
   } beat_t;

   int         checks = 0, errors = 0;
   int         cyc = 0, resp_count = 0, t_acc = 0, t_dv = 0;
   bit         mon_on = 0, tx_auto = 0, data_auto = 0, rx_auto = 0, rx_fixed_en = 0;
   int         rx_dmax = 0;
   logic [7:0] rx_fixed = 8'h00;
   beat_t      exp_q[$];
   beat_t      fired_q[$];
   logic       m_busy = 0, m_wait = 0, m_resp = 0, m_mvalid = 0, dv_prev = 0;
   logic [7:0] m_data = 0, last_data = 0;
   logic [31:0] m_addr = 0, m_next = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=event (t=%0t)", name, $time);
   endtask

   function automatic beat_t mk(input logic [7:0] bits, input logic [3:0] cnt, input logic [1:0] proto,
                                input logic iodir, input logic cs);
      beat_t b;
      b.bits = bits; b.cnt = cnt; b.proto = proto; b.iodir = iodir; b.cs = cs;
      return b;
   endfunction

   // Expected beat list for one accepted read, derived from the instruction fields.
   function automatic void plan(input logic [31:0] a);
      int  alen;
      bit  first, merged;
      alen   = (io_insn_addr_len > 3'd4) ? 4 : int'(io_insn_addr_len);
      merged = 0;
`ifdef SIRV_QSPI_XIP_MERGE_EN
      merged = m_mvalid && (a == m_next);
`endif
      m_mvalid = 0;
      first    = !merged;
      if (!merged) begin
         if (io_insn_cmd_en) begin
            exp_q.push_back(mk(io_insn_cmd_code, 4'd8, io_insn_cmd_proto, 1'b1, first));
            first = 0;
         end
         for (int i = alen - 1; i >= 0; i--) begin
            logic [31:0] sh;
            sh = a >> (8 * i);
            exp_q.push_back(mk(sh[7:0], 4'd8, io_insn_addr_proto, 1'b1, first));
            first = 0;
         end
         if (io_insn_pad_cnt != 4'd0) begin
            exp_q.push_back(mk(io_insn_pad_code, io_insn_pad_cnt, io_insn_data_proto, 1'b1, first));
            first = 0;
         end
      end
      exp_q.push_back(mk(8'h00, 4'd8, io_insn_data_proto, 1'b0, first));
   endfunction

   always @(negedge clock) begin
      beat_t b;
      cyc++;
      if (reset) begin
         exp_q.delete();
         m_busy = 0; m_wait = 0; m_resp = 0; m_mvalid = 0; dv_prev = 0;
      end else if (mon_on) begin
         b = mk(io_link_tx_bits, io_link_cnt, io_link_fmt_proto, io_link_fmt_iodir, io_link_cs_clear);
         check("lock", 32'(io_link_lock), 32'(m_busy));
         check("addr_ready", 32'(io_addr_ready), 32'(io_en && !m_busy));
         check("data_valid", 32'(io_data_valid), 32'(m_resp));
         if (m_resp) check("data_bits", 32'(io_data_bits), 32'(m_data));
         check("tx_valid", 32'(io_link_tx_valid), 32'(exp_q.size() != 0));
         if (io_link_tx_valid && exp_q.size() != 0) check("beat", 32'(b), 32'(exp_q[0]));
         if (!io_link_tx_valid) check("cs_idle", 32'(io_link_cs_clear), 32'(0));
         if (io_data_valid && !dv_prev) t_dv = cyc;
         dv_prev = io_data_valid;
         if (!m_busy && !io_en) m_mvalid = 0;
         if (io_addr_valid && io_addr_ready && !m_busy) begin
            plan(io_addr_bits);
            m_busy = 1; m_addr = io_addr_bits; t_acc = cyc;
         end
         if (m_resp && io_data_valid && io_data_ready) begin
            m_resp = 0; m_busy = 0; m_mvalid = 1; m_next = m_addr + 32'd1;
            last_data = io_data_bits;
            resp_count++;
         end
         if (m_wait && io_link_rx_valid) begin
            m_wait = 0; m_resp = 1; m_data = io_link_rx_bits;
         end
         if (io_link_tx_valid && io_link_tx_ready && exp_q.size() != 0) begin
            fired_q.push_back(b);
            if (!exp_q[0].iodir) m_wait = 1;
            void'(exp_q.pop_front());
         end
      end
   end

   initial forever begin
      @(posedge clock);
      #1;
      if (tx_auto) io_link_tx_ready = ($urandom % 4) != 0;
      if (data_auto) io_data_ready = ($urandom % 3) != 0;
   end

   initial forever begin
      @(negedge clock);
      if (rx_auto && !reset && io_link_tx_valid && io_link_tx_ready && !io_link_fmt_iodir) begin
         int d;
         d = int'($urandom_range(rx_dmax, 0));
         @(posedge clock);
         repeat (d) @(posedge clock);
         #1;
         io_link_rx_bits  = rx_fixed_en ? rx_fixed : 8'($urandom);
         io_link_rx_valid = 1'b1;
         @(posedge clock);
         #1;
         io_link_rx_valid = 1'b0;
      end
   end

   task automatic set_insn(input bit cen, input logic [7:0] code, input logic [1:0] cp, input logic [2:0] al,
                           input logic [1:0] ap, input logic [3:0] pc, input logic [7:0] pcode,
                           input logic [1:0] dp);
      io_en = 1'b0;
      @(posedge clock);
      #1;
      io_insn_cmd_en = cen; io_insn_cmd_code = code; io_insn_cmd_proto = cp;
      io_insn_addr_len = al; io_insn_addr_proto = ap; io_insn_pad_cnt = pc;
      io_insn_pad_code = pcode; io_insn_data_proto = dp;
      io_en = 1'b1;
   endtask

   task automatic do_read(input logic [31:0] a, input bit drop_en);
      int n, rc;
      rc = resp_count;
      fired_q.delete();
      io_addr_bits  = a;
      io_addr_valid = 1'b1;
      n = 0;
      @(negedge clock);
      while (!io_addr_ready && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (!io_addr_ready) begin
         fail_timeout("accept");
         io_addr_valid = 1'b0;
         return;
      end
      @(posedge clock);
      #1;
      io_addr_valid = 1'b0;
      io_addr_bits  = $urandom;
      if (drop_en) io_en = 1'b0;
      n = 0;
      while (resp_count == rc && n < 300) begin
         @(negedge clock);
         n++;
      end
      if (resp_count == rc) fail_timeout("response");
      @(posedge clock);
      #1;
      if (drop_en) io_en = 1'b1;
   endtask

   initial begin
      logic [7:0]  exp_b[5];
      logic [31:0] last_a;
      int          n, rc;
      exp_b = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h00};
      reset = 1'b1; io_en = 1'b1;
      io_insn_cmd_en = 0; io_insn_cmd_code = 0; io_insn_cmd_proto = 0; io_insn_addr_len = 0;
      io_insn_addr_proto = 0; io_insn_pad_cnt = 0; io_insn_pad_code = 0; io_insn_data_proto = 0;
      io_addr_valid = 0; io_addr_bits = 0; io_data_ready = 1; io_link_tx_ready = 1;
      io_link_rx_valid = 0; io_link_rx_bits = 0;
      mon_on = 1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_addr_ready", 32'(io_addr_ready), 32'(0));
      check("rst_tx_valid", 32'(io_link_tx_valid), 32'(0));
      check("rst_cnt", 32'(io_link_cnt), 32'(8));
      check("rst_lock", 32'(io_link_lock), 32'(0));
      check("rst_data_valid", 32'(io_data_valid), 32'(0));
      check("rst_data_bits", 32'(io_data_bits), 32'(0));
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check("idle_addr_ready", 32'(io_addr_ready), 32'(1));

      // full sequence, minimum latency
      rx_auto = 1; rx_fixed_en = 1; rx_fixed = 8'hA5; rx_dmax = 0;
      set_insn(1, 8'h03, 2'd0, 3'd3, 2'd0, 4'd0, 8'h00, 2'd0);
      do_read(32'h0012_3456, 0);
      check("full_nbeats", 32'(fired_q.size()), 32'(5));
      if (fired_q.size() == 5) begin
         for (int i = 0; i < 5; i++) check("full_bits", 32'(fired_q[i].bits), 32'(exp_b[i]));
         check("full_cs0", 32'(fired_q[0].cs), 32'(1));
         check("full_cs1", 32'(fired_q[1].cs), 32'(0));
         check("full_drx_iodir", 32'(fired_q[4].iodir), 32'(0));
      end
      check("full_data", 32'(last_data), 32'(8'hA5));
      check("full_latency", 32'(t_dv - t_acc), 32'(7));

      // quad with pad
      set_insn(1, 8'h6B, 2'd0, 3'd3, 2'd2, 4'd6, 8'hFF, 2'd2);
      do_read(32'h00AB_CDEF, 0);
      check("quad_nbeats", 32'(fired_q.size()), 32'(6));
      if (fired_q.size() == 6) begin
         check("quad_addr", 32'(fired_q[1]), 32'(mk(8'hAB, 4'd8, 2'd2, 1'b1, 1'b0)));
         check("quad_pad", 32'(fired_q[4]), 32'(mk(8'hFF, 4'd6, 2'd2, 1'b1, 1'b0)));
         check("quad_drx", 32'(fired_q[5]), 32'(mk(8'h00, 4'd8, 2'd2, 1'b0, 1'b0)));
      end

      // backpressure on the middle address byte and on the response
      set_insn(1, 8'h03, 2'd0, 3'd3, 2'd0, 4'd0, 8'h00, 2'd0);
      fired_q.delete();
      rc = resp_count;
      io_data_ready = 1'b0;
      io_addr_bits = 32'h0012_3456; io_addr_valid = 1'b1;
      @(negedge clock);
      check("bp_accept_ready", 32'(io_addr_ready), 32'(1));
      @(posedge clock);
      #1;
      io_addr_valid = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1;
      io_link_tx_ready = 1'b0;
      repeat (5) begin
         @(negedge clock);
         check("bp_tx_bits", 32'(io_link_tx_bits), 32'(8'h34));
         check("bp_tx_valid", 32'(io_link_tx_valid), 32'(1));
      end
      @(posedge clock);
      #1;
      io_link_tx_ready = 1'b1;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!io_data_valid && n < 50);
      if (!io_data_valid) fail_timeout("bp_data_valid");
      repeat (3) begin
         check("bp_dv_hold", 32'(io_data_valid), 32'(1));
         check("bp_bits_hold", 32'(io_data_bits), 32'(8'hA5));
         check("bp_addr_ready", 32'(io_addr_ready), 32'(0));
         @(negedge clock);
      end
      @(posedge clock);
      #1;
      io_data_ready = 1'b1;
      n = 0;
      while (resp_count == rc && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (resp_count == rc) fail_timeout("bp_response");
      check("bp_nbeats", 32'(fired_q.size()), 32'(5));
      if (fired_q.size() == 5)
         for (int i = 0; i < 5; i++) check("bp_bits", 32'(fired_q[i].bits), 32'(exp_b[i]));

      // minimal: DRX only, carrying cs_clear
      set_insn(0, 8'h00, 2'd0, 3'd0, 2'd0, 4'd0, 8'h00, 2'd1);
      do_read(32'h0000_0055, 0);
      check("min_nbeats", 32'(fired_q.size()), 32'(1));
      if (fired_q.size() == 1)
         check("min_beat", 32'(fired_q[0]), 32'(mk(8'h00, 4'd8, 2'd1, 1'b0, 1'b1)));

      // sequential-read merge
      set_insn(1, 8'h03, 2'd0, 3'd3, 2'd0, 4'd0, 8'h00, 2'd0);
      do_read(32'h0000_0100, 0);
      check("m1_nbeats", 32'(fired_q.size()), 32'(5));
      if (fired_q.size() != 0) check("m1_cs", 32'(fired_q[0].cs), 32'(1));
      do_read(32'h0000_0101, 0);
`ifdef SIRV_QSPI_XIP_MERGE_EN
      check("m2_nbeats", 32'(fired_q.size()), 32'(1));
      if (fired_q.size() != 0) check("m2_cs", 32'(fired_q[0].cs), 32'(0));
`else
      check("m2_nbeats", 32'(fired_q.size()), 32'(5));
      if (fired_q.size() != 0) check("m2_cs", 32'(fired_q[0].cs), 32'(1));
`endif
      do_read(32'h0000_0200, 0);
      check("m3_nbeats", 32'(fired_q.size()), 32'(5));
      if (fired_q.size() != 0) check("m3_cs", 32'(fired_q[0].cs), 32'(1));

      // reset while waiting for receive data
      rx_auto = 0;
      set_insn(1, 8'h0B, 2'd0, 3'd1, 2'd0, 4'd0, 8'h00, 2'd0);
      fired_q.delete();
      io_addr_bits = 32'h0000_0777; io_addr_valid = 1'b1;
      @(negedge clock);
      @(posedge clock);
      #1;
      io_addr_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!(fired_q.size() != 0 && fired_q[fired_q.size()-1].iodir == 1'b0) && n < 50);
      if (n >= 50) fail_timeout("wrx_reach");
      @(posedge clock);
      #1;
      @(negedge clock);
      check("wrx_lock", 32'(io_link_lock), 32'(1));
      check("wrx_tx_valid", 32'(io_link_tx_valid), 32'(0));
      @(posedge clock);
      #1;
      reset = 1'b1; io_en = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check("wrx_rst_lock", 32'(io_link_lock), 32'(0));
      check("wrx_rst_dv", 32'(io_data_valid), 32'(0));
      check("wrx_rst_cnt", 32'(io_link_cnt), 32'(8));
      @(posedge clock);
      #1;
      io_link_rx_bits = 8'h5A; io_link_rx_valid = 1'b1;
      @(posedge clock);
      #1;
      io_link_rx_valid = 1'b0;
      repeat (2) begin
         @(negedge clock);
         check("late_rx_dv", 32'(io_data_valid), 32'(0));
         check("late_rx_lock", 32'(io_link_lock), 32'(0));
      end
      @(posedge clock);
      #1;
      io_en = 1'b1;

      // randomized traffic against the model
      rx_auto = 1; rx_fixed_en = 0; rx_dmax = 3; tx_auto = 1; data_auto = 1;
      last_a = $urandom;
      for (int c = 0; c < 6; c++) begin
         set_insn(1'($urandom % 2), 8'($urandom), 2'($urandom % 3), 3'($urandom % 8), 2'($urandom % 3),
                  ($urandom % 3 == 0) ? 4'd0 : 4'($urandom % 16), 8'($urandom), 2'($urandom % 3));
         for (int r = 0; r < 8; r++) begin
            logic [31:0] a;
            a = ($urandom % 2 == 0) ? last_a + 32'd1 : 32'($urandom);
            do_read(a, ($urandom % 6) == 0);
            last_a = a;
         end
      end
      tx_auto = 0; data_auto = 0;
      repeat (3) @(posedge clock);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sirv_qspi_xip_seq.md
Name: sirv_qspi_xip_seq

Overview:
- Execute-in-place read sequencer that drives the QSPI link interface, the same link the QSPI FIFO drives, while the controller is in flash (memory-mapped) mode.
- Turns a byte-read request (address) into a link transaction: optional command byte, 0-4 address bytes, optional dummy phase, one received data byte.
- Returns that byte on a valid/ready response port.
- A downstream link mux selects between this block and the FIFO.

Parameters:
- ADDR_W, 32, request address width; must be >= 32.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- io_en  in  1  flash mode enable; new requests accepted only when 1
- io_insn_cmd_en  in  1  send command phase
- io_insn_cmd_code  in  8  command byte
- io_insn_cmd_proto  in  2  command protocol (0 single, 1 dual, 2 quad)
- io_insn_addr_len  in  3  address bytes 0-4; values >4 treated as 4
- io_insn_addr_proto  in  2  address protocol
- io_insn_pad_cnt  in  4  dummy cycles; 0 skips the pad phase
- io_insn_pad_code  in  8  byte driven during pad
- io_insn_data_proto  in  2  data/pad protocol
- io_addr_valid  in  1  request valid
- io_addr_ready  out  1  request accepted
- io_addr_bits  in  ADDR_W  byte address
- io_data_valid  out  1  read data valid
- io_data_ready  in  1  read data consumed
- io_data_bits  out  8  read data
- io_link_tx_ready  in  1  link accepts beat
- io_link_tx_valid  out  1  beat valid
- io_link_tx_bits  out  8  beat byte
- io_link_cnt  out  4  cycles in beat (8 for normal beats; pad_cnt for pad beat)
- io_link_fmt_proto  out  2  beat protocol
- io_link_fmt_iodir  out  1  1 = transmit, 0 = receive
- io_link_cs_clear  out  1  deassert/reassert CS before this beat
- io_link_rx_valid  in  1  received byte valid (one-cycle pulse)
- io_link_rx_bits  in  8  received byte
- io_link_lock  out  1  link owned by this block

Behaviour:
- Reset (synchronous; forces state IDLE from any state, mid-transaction included):
  - all outputs 0, except io_link_cnt = 8
  - captured address cleared; merge flag cleared
- Insn inputs are sampled live and must be held stable by software while io_en = 1.
- States: IDLE, CMD, ADDR, PAD, DRX, WRX, RESP.
- IDLE:
  - io_addr_ready = io_en.
  - On io_addr_valid & io_addr_ready, capture the address.
  - Next state: CMD if cmd_en, else ADDR if addr_len != 0, else PAD if pad_cnt != 0, else DRX.
- CMD:
  - tx_valid = 1, bits = cmd_code, proto = cmd_proto, iodir = 1, cnt = 8.
  - Advance on tx fire (tx_ready & tx_valid).
- ADDR:
  - Byte counter k counts down from addr_len-1 to 0; bits = addr[8k+7:8k], MSB first.
  - proto = addr_proto, iodir = 1.
  - Counter decrements on each fire; leave after the k = 0 fire.
- PAD:
  - One beat: bits = pad_code, cnt = pad_cnt, proto = data_proto, iodir = 1.
- DRX:
  - One beat: bits = 0x00, proto = data_proto, iodir = 0, cnt = 8. On fire go to WRX.
- WRX:
  - tx_valid = 0. Wait for rx_valid; capture rx_bits; go to RESP.
  - rx_valid in any other state is ignored.
- RESP:
  - io_data_valid = 1 and io_data_bits held stable until io_data_ready.
  - On fire go to IDLE; the next request can be accepted on the following cycle.
- Between beats: tx_valid is held and no beat field changes while tx_ready = 0.
- io_link_cs_clear = 1 only together with tx_valid on the first beat of a non-merged transaction, whichever phase that is.
- io_link_lock = 1 in every state except IDLE.
- io_en falling mid-transaction: the current transaction completes; no new request is accepted.
- Minimum latency, all phases enabled, addr_len = 3, tx_ready tied to 1, rx_valid returned 1 cycle after the DRX fire:
  - accept at T0; CMD at T1; ADDR T2-T4; PAD T5; DRX T6; rx at T7; data_valid at T8.

Optional Feature:
- Macro: SIRV_QSPI_XIP_MERGE_EN.
- Defined:
  - On RESP fire, store next_addr = addr + 1 (modulo 2^ADDR_W) and set the merge flag.
  - A request accepted while the flag is set and io_addr_bits == next_addr goes straight to DRX; no cs_clear is asserted.
  - Any other request clears the flag and runs the full sequence with cs_clear on its first beat.
  - The flag also clears when io_en = 0 in IDLE, and on reset.
- Undefined:
  - No flag; every transaction runs the full sequence with cs_clear on its first beat.

Test Plan:
- Full sequence: cmd_en=1, code 0x03, addr_len=3, pad_cnt=0, addr 0x00123456, tx_ready=1, rx 0xA5 -> beats 0x03(cs_clear=1), 0x12, 0x34, 0x56, DRX iodir=0; data_bits=0xA5; data_valid one cycle after rx_valid.
- Quad with pad: cmd_proto=0, addr_proto=2, data_proto=2, pad_cnt=6, pad_code 0xFF -> pad beat cnt=6, proto=2, bits=0xFF; DRX proto=2.
- Backpressure: tx_ready=0 for 5 cycles during ADDR k=1 -> tx_bits held at the middle address byte and no beat skipped; data_ready=0 for 3 cycles -> data_valid/data_bits held, addr_ready=0.
- Minimal: cmd_en=0, addr_len=0, pad_cnt=0 -> the first beat is DRX, carrying cs_clear=1.
- Reset in WRX -> next cycle state IDLE, lock=0, data_valid=0; a later rx_valid is ignored.
- With SIRV_QSPI_XIP_MERGE_EN: reads of 0x100 then 0x101 -> second read issues DRX only with cs_clear=0; then 0x200 -> full sequence with cs_clear=1. Without the macro, all three reads run the full sequence.
